riscv_test_monitor: RTL and testbench
=====================================

# riscv_test_monitor

Synthesizable pass/fail monitor for riscv-tests regressions on one or more harts. It snoops each hart's store port for writes to the `tohost` address and decodes the test result, with an optional legacy check on PC and `gp`. It also enforces a cycle timeout. It sits beside the core(s) in the simulation top, so benches read a small status vector instead of probing core internals.

## Interface
Parameters:
- NHART, 1, number of monitored harts (1–8)
- TOHOST_ADDR, 32'h0000_1000, byte address of the `tohost` word
- TIMEOUT, 5000, maximum cycles in RUN before timeout (≥2)
- PASS_PC, 32'h0000_0044, legacy pass-trap PC; used only with the macro

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that arms the monitor
- st_valid  in  NHART  per-hart store strobe
- st_addr  in  NHART*32  per-hart store byte address
- st_data  in  NHART*32  per-hart store data (full word)
- pc  in  NHART*32  per-hart current PC (legacy mode only)
- gp  in  NHART*32  per-hart x3 value (legacy mode only)
- done  out  1  result valid, sticky
- pass  out  1  all harts passed; meaningful only when done=1
- timeout  out  1  TIMEOUT expired before completion
- fail_hart  out  3  index of the first failing hart
- fail_id  out  31  failing test number (`tohost`>>1)
- hart_done  out  NHART  per-hart finished flags
- cycles  out  32  cycles spent in RUN; saturates at all-ones

## Operation
- States: IDLE → RUN → PASS | FAIL | TIMEOUT. The last three are terminal until reset.
- IDLE: counters cleared. A `start` pulse moves to RUN the next cycle. `start` in any other state is ignored.
- Per-hart qualifying event in RUN: st_valid=1, st_addr==TOHOST_ADDR, and st_data[0]==1.
  - st_data==1 marks the hart passed.
  - Any other value marks it failed with id=st_data[31:1].
  - Stores with st_data[0]==0 are ignored (syscall traffic).
- Events from a hart whose hart_done is already set are ignored.
- RUN → FAIL on the first failing event. fail_hart and fail_id are captured once and never overwritten.
- If several harts fail in the same cycle, the lowest index wins.
- RUN → PASS when every hart_done bit is set and no failure has occurred.
- RUN → TIMEOUT when cycles reaches TIMEOUT with the run incomplete.
- Outputs: done=1 in PASS/FAIL/TIMEOUT; pass=1 only in PASS; timeout=1 only in TIMEOUT.
- In terminal states, all inputs are ignored and outputs are frozen.
- Reset values: state IDLE; all outputs 0 (done, pass, timeout, fail_hart, fail_id, hart_done, cycles).

## Timing
- Inputs are sampled on rising clk. Decode and state update are registered.
- A qualifying store in cycle N is reflected in hart_done and done in cycle N+1 (1-cycle latency).
- cycles increments on every RUN cycle. The first RUN cycle shows cycles=1 the following cycle.
- Simultaneous completion and expiry: if the final pass store lands in the same cycle cycles reaches TIMEOUT, the result is PASS. A fail in that cycle gives FAIL. Completion always beats timeout.
- Reset mid-run: rst low forces all state and outputs to reset values immediately, without waiting for clk. Operation resumes only after rst high and a new `start`.

## Configuration
- Macro: RISCV_TEST_MONITOR_LEGACY_PC_EN.
- Defined: each hart also completes when pc==PASS_PC during RUN.
  - gp==1 at that point marks the hart passed.
  - Any other gp value marks it failed with id=gp>>1.
  - This event shares the fail-priority rules with `tohost` events.
  - If both a `tohost` event and a PC event fire for the same hart in one cycle, the `tohost` event wins.
- Not defined: the pc and gp ports are present but unused. Only `tohost` stores complete a hart.

## Structure
- Package riscv_test_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL, TIMEOUT)
  - the TOHOST_DEFAULT constant
  - the per-hart result encoding (NONE, OK, BAD)
- Sub-module riscv_tohost_decoder, instantiated NHART times. It is combinational from one hart's store and legacy signals to a {result, id} pair.
- The top holds the FSM, priority select, per-hart sticky flags and the cycle counter.

## Test plan
- NHART=1: start, then store 32'h1 to 0x1000 at cycle 10 → cycle 11: done=1, pass=1, hart_done=1, cycles=10.
- NHART=1: store 32'h0000_0007 → done=1, pass=0, fail_hart=0, fail_id=3. A later store of 32'h1 leaves the outputs unchanged.
- NHART=2: hart1 passes at cycle 5, hart0 stores 32'h1 at cycle 9 → done only at cycle 10, pass=1. A store of 32'h0000_0002 is ignored throughout.
- NHART=2, TIMEOUT=20: no stores → timeout=1, done=1 when cycles==20. Variant: pass store in that expiry cycle → pass=1, timeout=0.
- NHART=4: harts 3 and 1 store failing values 32'h9 and 32'h5 in the same cycle → fail_hart=1, fail_id=2.
- Reset low mid-RUN with hart_done=2'b01 → all outputs 0 at once. After restart, no stores, done stays 0 until timeout.

Source files
------------

// File: rtl/riscv_test_pkg.sv
// Shared types for the riscv-tests pass/fail monitor: FSM states, tohost default and
// per-hart result encoding.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPass,
    StFail,
    StTimeout
  } state_e;

  localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;

  typedef enum logic [1:0] {
    ResNone,
    ResOk,
    ResBad
  } res_e;

endpackage

// File: rtl/riscv_tohost_decoder.sv
// Combinational decode of one hart's tohost store (and legacy PC/gp trap when
// RISCV_TEST_MONITOR_LEGACY_PC_EN is defined) into a {result, id} pair.
module riscv_tohost_decoder
  import riscv_test_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT,
  parameter logic [31:0] PASS_PC     = 32'h0000_0044
) (
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  output res_e        result,
  output logic [30:0] id
);

  always_comb begin
    result = ResNone;
    id     = '0;
`ifdef RISCV_TEST_MONITOR_LEGACY_PC_EN
    if (pc == PASS_PC) begin
      result = (gp == 32'd1) ? ResOk : ResBad;
      id     = gp[31:1];
    end
`endif
    // Evaluated last so a tohost store overrides a same-cycle PC trap.
    // Stores with bit 0 clear are syscall traffic, not a result.
    if (st_valid && (st_addr == TOHOST_ADDR) && st_data[0]) begin
      result = (st_data == 32'd1) ? ResOk : ResBad;
      id     = st_data[31:1];
    end
  end

`ifndef RISCV_TEST_MONITOR_LEGACY_PC_EN
  logic unused_legacy;
  assign unused_legacy = ^{pc, gp, PASS_PC};
`endif

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv-tests pass/fail monitor: FSM, fail priority, per-hart done flags and cycle
// timeout. RISCV_TEST_MONITOR_LEGACY_PC_EN adds the PC/gp completion check.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int unsigned NHART       = 1,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT,
  parameter int unsigned TIMEOUT     = 5000,
  parameter logic [31:0] PASS_PC     = 32'h0000_0044
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NHART-1:0]      st_valid,
  input  logic [NHART*32-1:0]   st_addr,
  input  logic [NHART*32-1:0]   st_data,
  input  logic [NHART*32-1:0]   pc,
  input  logic [NHART*32-1:0]   gp,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [2:0]            fail_hart,
  output logic [30:0]           fail_id,
  output logic [NHART-1:0]      hart_done,
  output logic [31:0]           cycles
);

  state_e            state_q, state_d;
  logic [NHART-1:0]  hart_done_q;
  logic [31:0]       cycles_q, cycles_inc;
  logic [2:0]        fail_hart_q, bad_idx;
  logic [30:0]       fail_id_q, bad_id;
  logic [NHART-1:0]  new_done;
  logic              any_bad, all_done, timeout_hit;

  res_e        res [NHART];
  logic [30:0] id  [NHART];

  for (genvar g = 0; g < NHART; g++) begin : g_dec
    riscv_tohost_decoder #(
      .TOHOST_ADDR (TOHOST_ADDR),
      .PASS_PC     (PASS_PC)
    ) u_dec (
      .st_valid (st_valid[g]),
      .st_addr  (st_addr[g*32 +: 32]),
      .st_data  (st_data[g*32 +: 32]),
      .pc       (pc[g*32 +: 32]),
      .gp       (gp[g*32 +: 32]),
      .result   (res[g]),
      .id       (id[g])
    );
  end

  // Ascending scan keeps the first (lowest-index) failing hart.
  always_comb begin
    new_done = '0;
    any_bad  = 1'b0;
    bad_idx  = '0;
    bad_id   = '0;
    for (int i = 0; i < NHART; i++) begin
      if ((res[i] != ResNone) && !hart_done_q[i]) begin
        new_done[i] = 1'b1;
        if ((res[i] == ResBad) && !any_bad) begin
          any_bad = 1'b1;
          bad_idx = 3'(i);
          bad_id  = id[i];
        end
      end
    end
  end

  assign all_done    = &(hart_done_q | new_done);
  assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
  assign timeout_hit = (cycles_inc >= TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion is checked before expiry so a last-cycle result beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (any_bad)          state_d = StFail;
        else if (all_done)    state_d = StPass;
        else if (timeout_hit) state_d = StTimeout;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hart_done_q <= '0;
      cycles_q    <= '0;
      fail_hart_q <= '0;
      fail_id_q   <= '0;
    end else if (state_q == StIdle) begin
      hart_done_q <= '0;
      cycles_q    <= '0;
      fail_hart_q <= '0;
      fail_id_q   <= '0;
    end else if (state_q == StRun) begin
      hart_done_q <= hart_done_q | new_done;
      cycles_q    <= cycles_inc;
      if (any_bad) begin
        fail_hart_q <= bad_idx;
        fail_id_q   <= bad_id;
      end
    end
  end

  always_comb begin
    done    = 1'b0;
    pass    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StPass:    begin done = 1'b1; pass = 1'b1; end
      StFail:    done = 1'b1;
      StTimeout: begin done = 1'b1; timeout = 1'b1; end
      default:   done = 1'b0;
    endcase
  end

  assign hart_done = hart_done_q;
  assign cycles    = cycles_q;
  assign fail_hart = fail_hart_q;
  assign fail_id   = fail_id_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: three instances (1, 2 and 4 harts) share
// clock, reset and start; each scenario drives only the instance it targets.
module tb_riscv_test_monitor;

  localparam logic [31:0] TH = 32'h0000_1000;

  logic clk, rst, start;

  logic         a_valid;
  logic [31:0]  a_addr, a_data;
  logic [1:0]   b_valid;
  logic [63:0]  b_addr, b_data;
  logic [3:0]   c_valid;
  logic [127:0] c_addr, c_data;

  logic         a_done, a_pass, a_to;
  logic [2:0]   a_fh;
  logic [30:0]  a_fid;
  logic [0:0]   a_hd;
  logic [31:0]  a_cyc;

  logic         b_done, b_pass, b_to;
  logic [2:0]   b_fh;
  logic [30:0]  b_fid;
  logic [1:0]   b_hd;
  logic [31:0]  b_cyc;

  logic         c_done, c_pass, c_to;
  logic [2:0]   c_fh;
  logic [30:0]  c_fid;
  logic [3:0]   c_hd;
  logic [31:0]  c_cyc;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_test_monitor #(.NHART(1)) u_dut_a (
    .clk (clk), .rst (rst), .start (start),
    .st_valid (a_valid), .st_addr (a_addr), .st_data (a_data),
    .pc ('0), .gp ('0),
    .done (a_done), .pass (a_pass), .timeout (a_to), .fail_hart (a_fh),
    .fail_id (a_fid), .hart_done (a_hd), .cycles (a_cyc)
  );

  riscv_test_monitor #(.NHART(2), .TIMEOUT(20)) u_dut_b (
    .clk (clk), .rst (rst), .start (start),
    .st_valid (b_valid), .st_addr (b_addr), .st_data (b_data),
    .pc ('0), .gp ('0),
    .done (b_done), .pass (b_pass), .timeout (b_to), .fail_hart (b_fh),
    .fail_id (b_fid), .hart_done (b_hd), .cycles (b_cyc)
  );

  riscv_test_monitor #(.NHART(4), .TIMEOUT(20)) u_dut_c (
    .clk (clk), .rst (rst), .start (start),
    .st_valid (c_valid), .st_addr (c_addr), .st_data (c_data),
    .pc ('0), .gp ('0),
    .done (c_done), .pass (c_pass), .timeout (c_to), .fail_hart (c_fh),
    .fail_id (c_fid), .hart_done (c_hd), .cycles (c_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stores();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = '0;   b_addr = '0; b_data = '0;
    c_valid = '0;   c_addr = '0; c_data = '0;
  endtask

  task automatic do_reset();
    clear_stores();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  // Leaves the bench in the first RUN cycle.
  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    clear_stores();
    tick(2);

    check("rst_done",   a_done, 0);
    check("rst_pass",   a_pass, 0);
    check("rst_to",     a_to, 0);
    check("rst_fh",     a_fh, 0);
    check("rst_fid",    a_fid, 0);
    check("rst_hd",     a_hd, 0);
    check("rst_cyc",    a_cyc, 0);
    check("rst_b_cyc",  b_cyc, 0);

    rst = 1'b1;
    tick(2);
    check("idle_cyc", a_cyc, 0);

    // 1 hart: pass store in RUN cycle 10
    do_start();
    tick(9);
    check("p1_pre_done", a_done, 0);
    check("p1_pre_cyc",  a_cyc, 9);
    a_valid = 1'b1; a_addr = TH; a_data = 32'h1;
    tick(1);
    clear_stores();
    check("p1_done", a_done, 1);
    check("p1_pass", a_pass, 1);
    check("p1_hd",   a_hd, 1);
    check("p1_cyc",  a_cyc, 10);
    check("p1_to",   a_to, 0);
    tick(4);
    check("p1_frozen_cyc", a_cyc, 10);

    // 1 hart: failing store, later pass store ignored
    do_reset();
    do_start();
    tick(2);
    a_valid = 1'b1; a_addr = TH; a_data = 32'h7;
    tick(1);
    check("f1_done", a_done, 1);
    check("f1_pass", a_pass, 0);
    check("f1_fh",   a_fh, 0);
    check("f1_fid",  a_fid, 3);
    a_data = 32'h1;
    tick(3);
    clear_stores();
    check("f1_hold_pass", a_pass, 0);
    check("f1_hold_fid",  a_fid, 3);
    check("f1_hold_cyc",  a_cyc, 3);
    check("f1_hold_hd",   a_hd, 1);

    // 2 harts: hart1 at cycle 5, hart0 at cycle 9; syscall/off-address stores ignored
    do_reset();
    do_start();
    b_valid = 2'b01; b_addr[31:0] = TH; b_data[31:0] = 32'h2;
    tick(4);
    b_valid = 2'b11; b_addr[63:32] = TH; b_data[63:32] = 32'h1;
    tick(1);
    b_valid = 2'b01; b_addr[31:0] = TH + 32'd4; b_data[31:0] = 32'h1;
    check("p2_mid_hd",   b_hd, 2'b10);
    check("p2_mid_done", b_done, 0);
    tick(3);
    check("p2_pre_done", b_done, 0);
    check("p2_pre_hd",   b_hd, 2'b10);
    b_addr[31:0] = TH; b_data[31:0] = 32'h1;
    tick(1);
    clear_stores();
    check("p2_done", b_done, 1);
    check("p2_pass", b_pass, 1);
    check("p2_hd",   b_hd, 2'b11);
    check("p2_cyc",  b_cyc, 9);

    // 2 harts, TIMEOUT=20: no stores
    do_reset();
    do_start();
    tick(19);
    check("t2_pre_done", b_done, 0);
    check("t2_pre_cyc",  b_cyc, 19);
    tick(1);
    check("t2_done", b_done, 1);
    check("t2_to",   b_to, 1);
    check("t2_pass", b_pass, 0);
    check("t2_cyc",  b_cyc, 20);
    tick(3);
    check("t2_frozen_cyc", b_cyc, 20);

    // Final pass store lands in the expiry cycle: pass wins
    do_reset();
    do_start();
    tick(2);
    b_valid = 2'b10; b_addr[63:32] = TH; b_data[63:32] = 32'h1;
    tick(1);
    clear_stores();
    tick(16);
    check("tp_pre_done", b_done, 0);
    check("tp_pre_cyc",  b_cyc, 19);
    b_valid = 2'b01; b_addr[31:0] = TH; b_data[31:0] = 32'h1;
    tick(1);
    clear_stores();
    check("tp_pass", b_pass, 1);
    check("tp_to",   b_to, 0);
    check("tp_cyc",  b_cyc, 20);

    // 4 harts: harts 3 and 1 fail together, lower index wins
    do_reset();
    do_start();
    tick(1);
    c_valid = 4'b1010;
    c_addr[127:96] = TH; c_data[127:96] = 32'h9;
    c_addr[63:32]  = TH; c_data[63:32]  = 32'h5;
    tick(1);
    clear_stores();
    check("f4_done", c_done, 1);
    check("f4_pass", c_pass, 0);
    check("f4_fh",   c_fh, 1);
    check("f4_fid",  c_fid, 2);
    check("f4_hd",   c_hd, 4'b1010);

    // Asynchronous reset mid-RUN, then restart runs to timeout
    do_reset();
    do_start();
    b_valid = 2'b01; b_addr[31:0] = TH; b_data[31:0] = 32'h1;
    tick(1);
    clear_stores();
    tick(1);
    check("ar_pre_hd", b_hd, 2'b01);
    rst = 1'b0;
    #2;
    check("ar_hd",   b_hd, 0);
    check("ar_cyc",  b_cyc, 0);
    check("ar_done", b_done, 0);
    rst = 1'b1;
    tick(3);
    check("ar_idle_cyc", b_cyc, 0);
    do_start();
    tick(19);
    check("ar_run_done", b_done, 0);
    tick(1);
    check("ar_run_to",   b_to, 1);
    check("ar_run_hd",   b_hd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
